// File: rtl/rm_ihpsg13_bist_pkg.sv
// Shared types and March C- element tables for the IHP SG13 SRAM BIST controller.
// Each element is described by its address direction and the read/write patterns it applies.
package rm_ihpsg13_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        E0 = 3'd0,
        E1 = 3'd1,
        E2 = 3'd2,
        E3 = 3'd3,
        E4 = 3'd4,
        E5 = 3'd5
    } elem_e;

    typedef struct packed {
        logic down;    // 1: walk addresses NumWords-1 .. 0
        logic rd_pat;  // expected word on read (replicated across the word)
        logic wr_pat;  // written word (replicated across the word)
        logic has_rd;
        logic has_wr;
    } elem_cfg_t;

    // March C-: up(w0) up(r0,w1) up(r1,w0) down(r0,w1) down(r1,w0) up(r0)
    function automatic elem_cfg_t elem_cfg(input logic [2:0] elem);
        elem_cfg_t cfg;
        cfg = '0;
        case (elem)
            E0:      cfg = '{down: 1'b0, rd_pat: 1'b0, wr_pat: 1'b0, has_rd: 1'b0, has_wr: 1'b1};
            E1:      cfg = '{down: 1'b0, rd_pat: 1'b0, wr_pat: 1'b1, has_rd: 1'b1, has_wr: 1'b1};
            E2:      cfg = '{down: 1'b0, rd_pat: 1'b1, wr_pat: 1'b0, has_rd: 1'b1, has_wr: 1'b1};
            E3:      cfg = '{down: 1'b1, rd_pat: 1'b0, wr_pat: 1'b1, has_rd: 1'b1, has_wr: 1'b1};
            E4:      cfg = '{down: 1'b1, rd_pat: 1'b1, wr_pat: 1'b0, has_rd: 1'b1, has_wr: 1'b1};
            E5:      cfg = '{down: 1'b0, rd_pat: 1'b0, wr_pat: 1'b0, has_rd: 1'b1, has_wr: 1'b0};
            default: cfg = '0;
        endcase
        return cfg;
    endfunction

endpackage

// File: rtl/rm_ihpsg13_bist_ctrl.sv
// March C- BIST controller for a single-port SRAM macro: one op per cycle, read data
// compared one cycle after the read strobe, first failing address/element kept sticky.
module rm_ihpsg13_bist_ctrl
    import rm_ihpsg13_bist_pkg::*;
#(
    parameter int NumWords  = 256,
    parameter int DataWidth = 64,
    parameter int AddrWidth = $clog2(NumWords)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic [AddrWidth-1:0] fail_addr_o,
    output logic [2:0]           fail_elem_o,
    output logic                 bist_en_o,
    output logic                 bist_men_o,
    output logic                 bist_wen_o,
    output logic                 bist_ren_o,
    output logic [AddrWidth-1:0] bist_addr_o,
    output logic [DataWidth-1:0] bist_din_o,
    output logic [DataWidth-1:0] bist_bm_o,
    input  logic [DataWidth-1:0] bist_dout_i
);

    localparam logic [AddrWidth-1:0] AddrLast = AddrWidth'(NumWords - 1);

    state_e                 state_reg, state_next;
    elem_e                  elem_reg;
    logic [AddrWidth-1:0]   addr_reg;
    logic                   phase_reg;      // 1: write half of a read/write pair

    logic                   cmp_valid_reg;
    logic                   cmp_exp_reg;
    logic [AddrWidth-1:0]   cmp_addr_reg;
    logic [2:0]             cmp_elem_reg;

    logic                   done_reg;
    logic                   pass_reg;
    logic [AddrWidth-1:0]   fail_addr_reg;
    logic [2:0]             fail_elem_reg;

    elem_cfg_t              cfg;
    elem_cfg_t              cfg_inc;
    logic [2:0]             elem_inc;
    logic                   pair_first;
    logic                   op_is_read;
    logic                   addr_at_end;
    logic                   run_last;
    logic                   start_accept;
    logic                   mismatch;

    assign cfg          = elem_cfg(elem_reg);
    assign elem_inc     = elem_reg + 3'd1;
    assign cfg_inc      = elem_cfg(elem_inc);
    assign pair_first   = cfg.has_rd && cfg.has_wr && !phase_reg;
    assign op_is_read   = cfg.has_rd && !(cfg.has_wr && phase_reg);
    assign addr_at_end  = cfg.down ? (addr_reg == '0) : (addr_reg == AddrLast);
    assign run_last     = (elem_reg == E5) && addr_at_end;
    assign start_accept = ((state_reg == ST_IDLE) || (state_reg == ST_DONE)) && start_i;
    assign mismatch     = cmp_valid_reg && (bist_dout_i != {DataWidth{cmp_exp_reg}});

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE, ST_DONE: if (start_i) state_next = ST_RUN;
            ST_RUN:           if (run_last) state_next = ST_DRAIN;
            ST_DRAIN:         state_next = ST_DONE;
            default:          state_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy_o      = 1'b0;
        bist_men_o  = 1'b0;
        bist_wen_o  = 1'b0;
        bist_ren_o  = 1'b0;
        bist_addr_o = '0;
        bist_din_o  = '0;
        bist_bm_o   = '0;
        unique case (state_reg)
            ST_RUN: begin
                busy_o      = 1'b1;
                bist_men_o  = 1'b1;
                bist_ren_o  = op_is_read;
                bist_wen_o  = !op_is_read;
                bist_addr_o = addr_reg;
                bist_bm_o   = '1;
                bist_din_o  = {DataWidth{!op_is_read && cfg.wr_pat}};
            end
            ST_DRAIN: busy_o = 1'b1;
            default: ;
        endcase
    end

    assign bist_en_o = busy_o;

    // ---------------- element / address / phase sequencer ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            elem_reg  <= E0;
            addr_reg  <= '0;
            phase_reg <= 1'b0;
        end else if (start_accept) begin
            elem_reg  <= E0;
            addr_reg  <= '0;
            phase_reg <= 1'b0;
        end else if (state_reg == ST_RUN) begin
            if (pair_first) begin
                phase_reg <= 1'b1;
            end else begin
                phase_reg <= 1'b0;
                if (addr_at_end) begin
                    // Next element starts immediately at its own first address.
                    if (elem_reg != E5) begin
                        elem_reg <= elem_e'(elem_inc);
                        addr_reg <= cfg_inc.down ? AddrLast : '0;
                    end
                end else begin
                    addr_reg <= cfg.down ? (addr_reg - AddrWidth'(1)) : (addr_reg + AddrWidth'(1));
                end
            end
        end
    end

    // ---------------- compare pipeline ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmp_valid_reg <= 1'b0;
            cmp_exp_reg   <= 1'b0;
            cmp_addr_reg  <= '0;
            cmp_elem_reg  <= '0;
        end else begin
            cmp_valid_reg <= (state_reg == ST_RUN) && op_is_read;
            cmp_exp_reg   <= cfg.rd_pat;
            cmp_addr_reg  <= addr_reg;
            cmp_elem_reg  <= elem_reg;
        end
    end

    // ---------------- result registers ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_reg      <= 1'b0;
            pass_reg      <= 1'b0;
            fail_addr_reg <= '0;
            fail_elem_reg <= '0;
        end else if (start_accept) begin
            done_reg      <= 1'b0;
            pass_reg      <= 1'b1;
            fail_addr_reg <= '0;
            fail_elem_reg <= '0;
        end else begin
            if (state_reg == ST_DRAIN) begin
                done_reg <= 1'b1;
            end
            if (mismatch) begin
                pass_reg <= 1'b0;
                // pass_reg still high means this is the first mismatch of the run
                if (pass_reg) begin
                    fail_addr_reg <= cmp_addr_reg;
                    fail_elem_reg <= cmp_elem_reg;
                end
            end
        end
    end

    assign done_o      = done_reg;
    assign pass_o      = pass_reg;
    assign fail_addr_o = fail_addr_reg;
    assign fail_elem_o = fail_elem_reg;

endmodule
